// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweep sequencer and its helpers.
package sweep_pkg;

    // Largest number of function inputs a sweep is intended for.
    localparam int MAX_N_IN = 4;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    // Number of minterms covered by an n-input function.
    function automatic int num_minterms(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter used to hold a stimulus stable for a fixed number of
// cycles; zero is high once the loaded count has run out.
module sweep_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps two implementations of the same function through every minterm,
// records both truth tables and reports where and how often they disagree.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [N_IN-1:0]               drv,
    input  logic                          impl_a,
    input  logic                          impl_b,
    output logic                          busy,
    output logic                          done,
    output logic [num_minterms(N_IN)-1:0] table_a,
    output logic [num_minterms(N_IN)-1:0] table_b,
    output logic [num_minterms(N_IN)-1:0] mismatch_mask,
    output logic [N_IN:0]                 mismatch_cnt,
    output logic                          pass
);

    localparam int NM = num_minterms(N_IN);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST   = N_IN'(NM - 1);

    sweep_state_e    state;
    sweep_state_e    state_next;
    logic [N_IN-1:0] idx;
    logic            tmr_load;
    logic            tmr_enable;
    logic            tmr_zero;
    logic            diff;
    logic            last;
    logic [N_IN:0]   cnt_next;

    assign diff     = impl_a ^ impl_b;
    assign last     = (idx == LAST);
    assign cnt_next = mismatch_cnt + {{N_IN{1'b0}}, diff};

    assign drv  = idx;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    sweep_settle_timer #(
        .W (CW)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (RELOAD),
        .enable     (tmr_enable),
        .zero       (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and settle-timer control.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE;
                    tmr_load   = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_next = SAMPLE;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            SAMPLE: begin
                if (last) begin
                    state_next = DONE;
                end else begin
                    state_next = SETTLE;
                    tmr_load   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Minterm index and result registers; pass is decided on the final sample
    // so that it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            table_a       <= '0;
            table_b       <= '0;
            mismatch_mask <= '0;
            mismatch_cnt  <= '0;
            pass          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= '0;
                        table_a       <= '0;
                        table_b       <= '0;
                        mismatch_mask <= '0;
                        mismatch_cnt  <= '0;
                        pass          <= 1'b0;
                    end
                end
                SAMPLE: begin
                    table_a[idx]       <= impl_a;
                    table_b[idx]       <= impl_b;
                    mismatch_mask[idx] <= diff;
                    mismatch_cnt       <= cnt_next;
                    if (last) begin
                        pass <= (cnt_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised bench for truth_table_sweeper: two instances (settle 1 and 3)
// checked every cycle against a position-based behavioural model.
module tb_truth_table_sweeper;
    import sweep_pkg::*;

    localparam int NM = 4;
    localparam int S0 = 1;
    localparam int S1 = 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start   = 1'b0;
    logic [3:0] lut_a = 4'b0010;
    logic [3:0] lut_b = 4'b0010;
    logic glitch_en = 1'b0;
    logic gl0 = 1'b0;
    logic gl1 = 1'b0;

    logic [1:0] drv0, drv1;
    logic       ia0, ib0, ia1, ib1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] ta0, tb0, mm0, ta1, tb1, mm1;
    logic [2:0] cnt0, cnt1;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    int         pos[2]        = '{0, 0};
    logic [3:0] mta[2]        = '{4'd0, 4'd0};
    logic [3:0] mtb[2]        = '{4'd0, 4'd0};
    logic       mpass[2]      = '{1'b0, 1'b0};
    int         start_edge[2] = '{0, 0};
    int         last_done[2]  = '{0, 0};
    int         done_cnt[2]   = '{0, 0};

    always #5 clk = ~clk;

    assign ia0 = lut_a[drv0] ^ gl0;
    assign ib0 = lut_b[drv0];
    assign ia1 = lut_a[drv1] ^ gl1;
    assign ib1 = lut_b[drv1];

    truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .drv(drv0),
        .impl_a(ia0), .impl_b(ib0), .busy(busy0), .done(done0),
        .table_a(ta0), .table_b(tb0), .mismatch_mask(mm0),
        .mismatch_cnt(cnt0), .pass(pass0)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .drv(drv1),
        .impl_a(ia1), .impl_b(ib1), .busy(busy1), .done(done1),
        .table_a(ta1), .table_b(tb1), .mismatch_mask(mm1),
        .mismatch_cnt(cnt1), .pass(pass1)
    );

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    // Cycles from the start edge to the end of the last sample.
    function automatic int span(input int i);
        return NM * (settle_of(i) + 1);
    endfunction

    // pos = k means the current cycle is the k-th after the start edge (0 = idle).
    function automatic bit in_sample(input int i);
        int p;
        int s;
        p = pos[i];
        s = settle_of(i);
        return (p != 0) && (p <= span(i)) && (((p - 1) % (s + 1)) == s);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic modelStep(input int i, input logic a, input logic b);
        int s;
        int m;
        s = settle_of(i);
        if (pos[i] == 0) begin
            if (start) begin
                mta[i]        = 4'd0;
                mtb[i]        = 4'd0;
                mpass[i]      = 1'b0;
                pos[i]        = 1;
                start_edge[i] = cyc;
            end
        end else if (pos[i] <= span(i)) begin
            if (((pos[i] - 1) % (s + 1)) == s) begin
                m         = (pos[i] - 1) / (s + 1);
                mta[i][m] = a;
                mtb[i][m] = b;
                if (m == NM - 1) begin
                    mpass[i] = ($countones(mta[i] ^ mtb[i]) == 0);
                end
            end
            pos[i]++;
        end else begin
            pos[i] = 0;
        end
    endtask

    task automatic checkInst(input int i, input logic [1:0] drv, input logic busy,
                             input logic done, input logic [3:0] ta, input logic [3:0] tb,
                             input logic [3:0] mm, input logic [2:0] cnt, input logic pass);
        int p;
        int s;
        int e_drv;
        logic [3:0] e_mask;
        p = pos[i];
        s = settle_of(i);
        if (p == 0)            e_drv = 0;
        else if (p <= span(i)) e_drv = (p - 1) / (s + 1);
        else                   e_drv = NM - 1;
        e_mask = mta[i] ^ mtb[i];
        checkOutput($sformatf("inst%0d drv", i), 32'(drv), 32'(e_drv));
        checkOutput($sformatf("inst%0d busy", i), 32'(busy), 32'(p != 0));
        checkOutput($sformatf("inst%0d done", i), 32'(done), 32'(p == span(i) + 1));
        checkOutput($sformatf("inst%0d table_a", i), 32'(ta), 32'(mta[i]));
        checkOutput($sformatf("inst%0d table_b", i), 32'(tb), 32'(mtb[i]));
        checkOutput($sformatf("inst%0d mismatch_mask", i), 32'(mm), 32'(e_mask));
        checkOutput($sformatf("inst%0d mismatch_cnt", i), 32'(cnt), 32'($countones(e_mask)));
        checkOutput($sformatf("inst%0d pass", i), 32'(pass), 32'(mpass[i]));
    endtask

    // Behavioural model: advances each instance's sweep position on every edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pos[i]   = 0;
                mta[i]   = 4'd0;
                mtb[i]   = 4'd0;
                mpass[i] = 1'b0;
            end
        end else begin
            cyc++;
            modelStep(0, ia0, ib0);
            modelStep(1, ia1, ib1);
        end
    end

    // Compare process: every output of both instances against the model.
    always @(negedge clk) begin
        checkInst(0, drv0, busy0, done0, ta0, tb0, mm0, cnt0, pass0);
        checkInst(1, drv1, busy1, done1, ta1, tb1, mm1, cnt1, pass1);
        if (done0) begin
            done_cnt[0]++;
            last_done[0] = cyc;
        end
        if (done1) begin
            done_cnt[1]++;
            last_done[1] = cyc;
        end
    end

    // Disturb impl_a outside sample cycles when glitching is enabled.
    always @(negedge clk) begin
        gl0 = glitch_en && !in_sample(0) && ($urandom_range(0, 1) == 1);
        gl1 = glitch_en && !in_sample(1) && ($urandom_range(0, 1) == 1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] lutb, input logic glitch);
        lut_b     = lutb;
        glitch_en = glitch;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((busy0 || busy1 || pos[0] != 0 || pos[1] != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) reportTimeout("wait idle");
        tick();
    endtask

    task automatic checkClean0(input string tag);
        checkOutput({tag, " table_a"}, 32'(ta0), 32'h2);
        checkOutput({tag, " table_b"}, 32'(tb0), 32'h2);
        checkOutput({tag, " mask"}, 32'(mm0), 32'h0);
        checkOutput({tag, " cnt"}, 32'(cnt0), 32'h0);
        checkOutput({tag, " pass"}, 32'(pass0), 32'h1);
    endtask

    initial begin
        int n;
        int d1;
        int d2;

        // Reset state
        repeat (3) tick();
        checkOutput("reset busy", 32'(busy0), 32'h0);
        checkOutput("reset done", 32'(done0), 32'h0);
        checkOutput("reset drv", 32'(drv0), 32'h0);
        checkOutput("reset table_a", 32'(ta0), 32'h0);
        checkOutput("reset cnt", 32'(cnt0), 32'h0);
        checkOutput("reset pass", 32'(pass0), 32'h0);
        rst_n = 1'b1;
        tick();

        // Both implementations correct a'.b
        $display("[TB] clean sweep");
        applyStimulus(4'b0010, 1'b0);
        waitIdle(200);
        checkClean0("clean");
        checkOutput("clean done latency s1", 32'(last_done[0] - start_edge[0] + 1), 32'd9);
        checkOutput("clean done latency s3", 32'(last_done[1] - start_edge[1] + 1), 32'd17);
        checkOutput("clean s3 table_a", 32'(ta1), 32'h2);

        // impl_b stuck at 1
        $display("[TB] stuck-at-1 sweep");
        applyStimulus(4'b1111, 1'b0);
        waitIdle(200);
        checkOutput("stuck table_b", 32'(tb0), 32'hf);
        checkOutput("stuck mask", 32'(mm0), 32'hd);
        checkOutput("stuck cnt", 32'(cnt0), 32'd3);
        checkOutput("stuck pass", 32'(pass0), 32'h0);

        // Extra start pulses mid-sweep and during DONE are ignored
        $display("[TB] ignored start pulses");
        done_cnt[0] = 0;
        applyStimulus(4'b0010, 1'b0);
        n = 0;
        while (drv0 != 2'd1 && n < 50) begin tick(); n++; end
        if (n >= 50) reportTimeout("wait minterm 1");
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done0 && n < 50) begin tick(); n++; end
        if (n >= 50) reportTimeout("wait done");
        start = 1'b1;
        tick();
        start = 1'b0;
        waitIdle(200);
        checkOutput("repulse done count", 32'(done_cnt[0]), 32'd1);
        checkClean0("repulse");

        // Asynchronous reset during SAMPLE of minterm 2
        $display("[TB] reset mid-sweep");
        applyStimulus(4'b1111, 1'b0);
        n = 0;
        while (pos[0] != 6 && n < 50) begin tick(); n++; end
        if (n >= 50) reportTimeout("wait sample m2");
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async rst busy", 32'(busy0), 32'h0);
        checkOutput("async rst drv", 32'(drv0), 32'h0);
        checkOutput("async rst table_b", 32'(tb0), 32'h0);
        checkOutput("async rst mask", 32'(mm0), 32'h0);
        checkOutput("async rst cnt", 32'(cnt0), 32'h0);
        checkOutput("async rst s3 busy", 32'(busy1), 32'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(4'b0010, 1'b0);
        waitIdle(200);
        checkClean0("after reset");

        // Glitching impl_a outside sample cycles
        $display("[TB] glitch during settle");
        applyStimulus(4'b0010, 1'b1);
        waitIdle(200);
        glitch_en = 1'b0;
        checkOutput("glitch s3 table_a", 32'(ta1), 32'h2);
        checkOutput("glitch s3 pass", 32'(pass1), 32'h1);
        checkOutput("glitch s3 latency", 32'(last_done[1] - start_edge[1] + 1), 32'd17);

        // start tied high: back-to-back sweeps
        $display("[TB] back-to-back sweeps");
        lut_b = 4'b0010;
        tick();
        start = 1'b1;
        n = 0;
        while (!done0 && n < 50) begin tick(); n++; end
        if (n >= 50) reportTimeout("wait first done");
        d1 = cyc;
        tick();
        checkOutput("b2b idle busy", 32'(busy0), 32'h0);
        checkOutput("b2b idle drv", 32'(drv0), 32'h0);
        tick();
        checkOutput("b2b restart busy", 32'(busy0), 32'h1);
        checkOutput("b2b cleared table_a", 32'(ta0), 32'h0);
        n = 0;
        while (!done0 && n < 50) begin tick(); n++; end
        if (n >= 50) reportTimeout("wait second done");
        d2 = cyc;
        start = 1'b0;
        checkOutput("b2b done spacing", 32'(d2 - d1), 32'd10);
        waitIdle(200);

        // Random functions, glitching and stray start pulses
        $display("[TB] random sweeps");
        for (int k = 0; k < 10; k++) begin
            lut_a = 4'($urandom);
            applyStimulus(4'($urandom), 1'($urandom));
            for (int j = 0; j < 12; j++) begin
                start = ($urandom_range(0, 3) == 0);
                tick();
            end
            start = 1'b0;
            waitIdle(200);
            glitch_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] bench did not finish");
    end

endmodule
